char_case_split: RTL and testbench
==================================

CHAR_CASE_SPLIT -- requirements
Module: char_case_split

Interface
REQ-001 Parameter: DEPTH, default 4, number of FIFO entries; power of two, 2..16.
REQ-002 Port: clk  input  1  single clock; all logic samples on the rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: in_valid  input  1  in_data holds a byte to be accepted.
REQ-005 Port: in_data  input  8  ASCII byte from the upstream character source.
REQ-006 Port: in_ready  output  1  FIFO can accept a byte this cycle.
REQ-007 Port: out_ready  input  1  downstream checker consumes the current output this cycle.
REQ-008 Port: flow_valid  output  1  cap_flow and low_flow hold one classified character.
REQ-009 Port: cap_flow  output  8  uppercase letter, otherwise 8'h00.
REQ-010 Port: low_flow  output  8  lowercase letter, otherwise 8'h00.
REQ-011 Port: letter_cnt  output  16  count of letters delivered, saturating.
REQ-012 Port: other_cnt  output  16  count of non-letters delivered, saturating.

Function
REQ-013 A byte SHALL be accepted on any rising edge where in_valid=1 and in_ready=1.
REQ-014 Definition: in_ready = (fifo_count < DEPTH), with no dependency on out_ready.
  - A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
REQ-015 The FIFO SHALL preserve byte order; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-016 Output stage load condition: (!flow_valid || out_ready) && fifo_count > 0.
  - On that edge, the FIFO head SHALL be popped into the registered output stage.
REQ-017 Loaded byte in 8'h41..8'h5A: cap_flow = byte, low_flow = 8'h00.
REQ-018 Loaded byte in 8'h61..8'h7A: low_flow = byte, cap_flow = 8'h00.
REQ-019 Any other loaded byte (space, digits, punctuation, 8'h00, 8'h80..8'hFF): cap_flow = low_flow = 8'h00, flow_valid = 1.
  - The separator is delivered so the downstream word checker can restart.
REQ-020 When flow_valid=1 and out_ready=0, cap_flow, low_flow and flow_valid SHALL hold unchanged.
REQ-021 When out_ready=1 and fifo_count = 0, flow_valid SHALL drop to 0 and both flows SHALL become 8'h00 on the next edge.
REQ-022 Latency with the FIFO empty and the output stage free: a byte accepted at edge k SHALL appear on the outputs after edge k+1.
  - No combinational path from in_data to the outputs.
REQ-023 Throughput: with out_ready held at 1 and in_valid continuous, one character per cycle SHALL be delivered.
REQ-024 Counter update: on each edge where flow_valid=1 and out_ready=1, letter_cnt or other_cnt SHALL increment by 1 according to the delivered class.
  - Each counter saturates at 16'hFFFF.
REQ-025 FIFO pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
  - fifo_count SHALL be log2(DEPTH)+1 bits.

Reset
REQ-026 While rst=1 at a rising edge, the following SHALL clear to 0:
  - fifo_count and both FIFO pointers
  - flow_valid, cap_flow and low_flow
  - letter_cnt and other_cnt
REQ-027 in_ready SHALL be 0 during any cycle where rst=1 is sampled, and 1 on the cycle after reset is released.
REQ-028 Reset asserted mid-stream SHALL discard all buffered bytes; no byte accepted before reset SHALL appear afterwards.
REQ-029 FIFO storage contents need not be reset.

Structure
REQ-030 Shared package char_flow_pkg SHALL hold the ASCII bounds (8'h41, 8'h5A, 8'h61, 8'h7A), the separator value 8'h00, and a class enum {CLS_CAP, CLS_LOW, CLS_OTHER}.
  - char_check_iloveyou and the other flow stages SHALL reuse the same package.
REQ-031 The FIFO SHALL be a separate sub-module, char_sync_fifo (parameter DEPTH, 8-bit data).
  - Classification and counters SHALL stay in char_case_split.

Verification
REQ-032 Stream "I love" (8'h49, 8'h20, 8'h6C, 8'h6F, 8'h76, 8'h65), out_ready=1 -> expected output:
  - cap_flow 49, 00, 00, 00, 00, 00
  - low_flow 00, 00, 6C, 6F, 76, 65
  - letter_cnt=5, other_cnt=1
REQ-033 Backpressure: out_ready=0 with 6 bytes offered, DEPTH=4.
  - After 5 accepts (4 in FIFO plus 1 held in the output stage), in_ready=0.
  - Raising out_ready delivers all 5 bytes in order with no loss or duplication.
REQ-034 Full plus pop: at fifo_count=4, in_valid=1 and out_ready=1 -> in_ready=0 that cycle and fifo_count=3 next cycle.
REQ-035 Reset mid-stream: assert rst for 1 cycle with 3 bytes buffered -> flow_valid=0, counters 0, first output after release is the first post-reset byte.
REQ-036 Boundary bytes 8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B, 8'hC1 -> classes OTHER, CAP, CAP, OTHER, OTHER, LOW, LOW, OTHER, OTHER.
REQ-037 Saturation: preload or drive 65,537 letters -> letter_cnt holds 16'hFFFF and other_cnt is unaffected.

Source files
------------

// File: rtl/char_flow_pkg.sv
// Shared definitions for the character flow stages: ASCII letter bounds,
// the separator byte and the character class.
package char_flow_pkg;

    localparam logic [7:0]  ASCII_CAP_LO = 8'h41;  // 'A'
    localparam logic [7:0]  ASCII_CAP_HI = 8'h5A;  // 'Z'
    localparam logic [7:0]  ASCII_LOW_LO = 8'h61;  // 'a'
    localparam logic [7:0]  ASCII_LOW_HI = 8'h7A;  // 'z'
    localparam logic [7:0]  SEP_BYTE     = 8'h00;  // emitted on the flow that does not carry the char
    localparam logic [15:0] CNT_MAX      = 16'hFFFF;

    typedef enum logic [1:0] {
        CLS_CAP,
        CLS_LOW,
        CLS_OTHER
    } char_cls_e;

    // Everything outside the two letter ranges (digits, punctuation,
    // control and high-bit bytes) is a word separator.
    function automatic char_cls_e classify(input logic [7:0] b);
        if (b >= ASCII_CAP_LO && b <= ASCII_CAP_HI)      return CLS_CAP;
        else if (b >= ASCII_LOW_LO && b <= ASCII_LOW_HI) return CLS_LOW;
        else                                             return CLS_OTHER;
    endfunction

endpackage

// File: rtl/char_case_split_if.sv
// Byte-stream bus for char_case_split: upstream valid/ready byte input,
// downstream classified flows with a ready-only consumer, plus counters.
interface char_case_split_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_ready;
    logic        flow_valid;
    logic [7:0]  cap_flow;
    logic [7:0]  low_flow;
    logic [15:0] letter_cnt;
    logic [15:0] other_cnt;

    // Character source and checker side.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, flow_valid, cap_flow, low_flow, letter_cnt, other_cnt
    );

    // Splitter side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, flow_valid, cap_flow, low_flow, letter_cnt, other_cnt
    );
endinterface

// File: rtl/char_sync_fifo.sv
// Single-clock byte FIFO. Head is presented combinationally on dout;
// pointers wrap modulo DEPTH (DEPTH must be a power of two).
module char_sync_fifo #(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    // Full refuses a push even if a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Control state register, cleared synchronously.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/char_case_split.sv
// Splits an ASCII byte stream into an uppercase flow and a lowercase flow.
// Non-letters are delivered as an all-zero separator so the word checker
// downstream can restart. Buffered through char_sync_fifo into a single
// registered output stage; counts delivered letters and non-letters.
module char_case_split
    import char_flow_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    char_case_split_if.slave  bus
);

    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_head;
    logic        push, pop;

    logic        flow_valid_q, flow_valid_d;
    logic [7:0]  cap_flow_q, cap_flow_d;
    logic [7:0]  low_flow_q, low_flow_d;
    logic [15:0] letter_cnt_q, letter_cnt_d;
    logic [15:0] other_cnt_q, other_cnt_d;
    logic        deliver, held_is_letter;

    // in_ready is purely occupancy based and held low while in reset.
    assign bus.in_ready = !rst && !fifo_full;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (!flow_valid_q || bus.out_ready) && !fifo_empty && !rst;
    assign deliver      = flow_valid_q && bus.out_ready;
    // Letters are never 8'h00, so a non-zero flow identifies a letter.
    assign held_is_letter = ((cap_flow_q | low_flow_q) != SEP_BYTE);

    char_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.in_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Output stage load/drain and delivered-class counters.
    always_comb begin
        flow_valid_d = flow_valid_q;
        cap_flow_d   = cap_flow_q;
        low_flow_d   = low_flow_q;
        letter_cnt_d = letter_cnt_q;
        other_cnt_d  = other_cnt_q;

        if (pop) begin
            flow_valid_d = 1'b1;
            cap_flow_d   = SEP_BYTE;
            low_flow_d   = SEP_BYTE;
            case (classify(fifo_head))
                CLS_CAP: cap_flow_d = fifo_head;
                CLS_LOW: low_flow_d = fifo_head;
                default: ;
            endcase
        end else if (bus.out_ready) begin
            flow_valid_d = 1'b0;
            cap_flow_d   = SEP_BYTE;
            low_flow_d   = SEP_BYTE;
        end

        if (deliver) begin
            if (held_is_letter) begin
                if (letter_cnt_q != CNT_MAX) letter_cnt_d = letter_cnt_q + 16'd1;
            end else begin
                if (other_cnt_q != CNT_MAX) other_cnt_d = other_cnt_q + 16'd1;
            end
        end
    end

    // Output stage and counter registers, cleared synchronously.
    always_ff @(posedge clk) begin
        if (rst) begin
            flow_valid_q <= 1'b0;
            cap_flow_q   <= '0;
            low_flow_q   <= '0;
            letter_cnt_q <= '0;
            other_cnt_q  <= '0;
        end else begin
            flow_valid_q <= flow_valid_d;
            cap_flow_q   <= cap_flow_d;
            low_flow_q   <= low_flow_d;
            letter_cnt_q <= letter_cnt_d;
            other_cnt_q  <= other_cnt_d;
        end
    end

    assign bus.flow_valid = flow_valid_q;
    assign bus.cap_flow   = cap_flow_q;
    assign bus.low_flow   = low_flow_q;
    assign bus.letter_cnt = letter_cnt_q;
    assign bus.other_cnt  = other_cnt_q;

endmodule

// File: tb/tb_char_case_split.sv
// Bench for char_case_split: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_char_case_split;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    char_case_split_if bus ();

    char_case_split #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    // reference model state
    logic [7:0]  fifo_m[$];
    bit          mv;
    logic [7:0]  mb;
    int unsigned lc, oc;

    // observations taken from the DUT for directed order checks
    logic [15:0] dlv_q[$];
    int          n_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cls_of(input logic [7:0] b);
        if (b >= 8'h41 && b <= 8'h5A) return 0;
        if (b >= 8'h61 && b <= 8'h7A) return 1;
        return 2;
    endfunction

    // One clock: drive inputs after the falling edge, compare outputs to
    // the model, then advance the model across the rising edge.
    task automatic step(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
        bit psh, dlv, ld;
        rst = r;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        if (check_en) begin
            chk("in_ready",   bus.in_ready, 32'(!r && fifo_m.size() < DEPTH));
            chk("flow_valid", bus.flow_valid, 32'(mv));
            chk("cap_flow",   bus.cap_flow, (mv && cls_of(mb) == 0) ? 32'(mb) : 32'h0);
            chk("low_flow",   bus.low_flow, (mv && cls_of(mb) == 1) ? 32'(mb) : 32'h0);
            chk("letter_cnt", bus.letter_cnt, lc);
            chk("other_cnt",  bus.other_cnt, oc);
        end
        if (bus.flow_valid && ordy) dlv_q.push_back({bus.cap_flow, bus.low_flow});
        if (iv && bus.in_ready) n_acc++;
        @(posedge clk);
        if (r) begin
            fifo_m.delete();
            mv = 0; mb = 8'h00; lc = 0; oc = 0;
        end else begin
            psh = iv && (fifo_m.size() < DEPTH);
            dlv = mv && ordy;
            ld  = (!mv || ordy) && (fifo_m.size() > 0);
            if (dlv) begin
                if (cls_of(mb) != 2) begin if (lc < 65535) lc++; end
                else begin if (oc < 65535) oc++; end
            end
            if (ld) begin mb = fifo_m.pop_front(); mv = 1; end
            else if (ordy) begin mv = 0; mb = 8'h00; end
            if (psh) fifo_m.push_back(d);
        end
        @(negedge clk);
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 3))
            0: return 8'(8'h41 + $urandom_range(0, 25));
            1: return 8'(8'h61 + $urandom_range(0, 25));
            2: return 8'(8'h3F + $urandom_range(0, 62));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    logic [7:0] love [6]  = '{8'h49, 8'h20, 8'h6C, 8'h6F, 8'h76, 8'h65};
    logic [7:0] bnd  [9]  = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B, 8'hC1};
    int         bcls [9]  = '{2, 0, 0, 2, 2, 1, 1, 2, 2};

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
        mv = 0; mb = 8'h00; lc = 0; oc = 0; n_acc = 0;
        @(negedge clk);

        // reset: outputs are unknown until the first reset edge
        step(1, 0, 8'h00, 0);
        step(1, 1, 8'h41, 1);
        check_en = 1'b1;
        step(1, 1, 8'h41, 1);       // reset state, in_ready low while rst
        step(0, 0, 8'h00, 0);       // in_ready high after release

        // "I love" stream
        foreach (love[i]) step(0, 1, love[i], 1);
        repeat (4) step(0, 0, 8'h00, 1);
        chk("love_letters", bus.letter_cnt, 32'd5);
        chk("love_other",   bus.other_cnt,  32'd1);

        // backpressure: 6 offered, 5 taken, then drained in order
        step(1, 0, 8'h00, 0);
        dlv_q.delete(); n_acc = 0;
        for (int i = 0; i < 6; i++) step(0, 1, 8'(8'h41 + i), 0);
        chk("bp_in_ready", bus.in_ready, 32'd0);
        chk("bp_accepts",  n_acc, 32'd5);
        repeat (7) step(0, 0, 8'h00, 1);
        chk("bp_count", dlv_q.size(), 32'd5);
        for (int i = 0; i < 5 && i < dlv_q.size(); i++)
            chk("bp_order", dlv_q[i], {8'(8'h41 + i), 8'h00});

        // full plus pop on the same edge
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h61 + i), 0);
        chk("fp_in_ready", bus.in_ready, 32'd0);
        step(0, 1, 8'h7A, 1);
        chk("fp_fifo_count", dut.u_fifo.count_q, 32'd3);
        repeat (6) step(0, 0, 8'h00, 1);

        // reset mid-stream with 3 bytes buffered
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h31 + i), 0);
        step(1, 0, 8'h00, 0);
        chk("rst_flow_valid", bus.flow_valid, 32'd0);
        chk("rst_letter_cnt", bus.letter_cnt, 32'd0);
        chk("rst_other_cnt",  bus.other_cnt,  32'd0);
        step(0, 1, 8'h5A, 1);
        step(0, 0, 8'h00, 0);
        chk("rst_first_valid", bus.flow_valid, 32'd1);
        chk("rst_first_byte",  bus.cap_flow,   32'h5A);
        repeat (3) step(0, 0, 8'h00, 1);

        // class boundaries
        dlv_q.delete();
        foreach (bnd[i]) step(0, 1, bnd[i], 1);
        repeat (4) step(0, 0, 8'h00, 1);
        chk("bnd_count", dlv_q.size(), 32'd9);
        for (int i = 0; i < 9 && i < dlv_q.size(); i++)
            chk("bnd_class",
                (dlv_q[i][15:8] != 0) ? 32'd0 : (dlv_q[i][7:0] != 0) ? 32'd1 : 32'd2,
                32'(bcls[i]));

        // randomized traffic with occasional resets
        repeat (2000)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                 rand_byte(), $urandom_range(0, 2) != 0);
        repeat (6) step(0, 0, 8'h00, 1);

        // letter counter saturation
        step(1, 0, 8'h00, 0);
        repeat (65540) step(0, 1, 8'h61, 1);
        chk("sat_letter_cnt", bus.letter_cnt, 32'hFFFF);
        chk("sat_other_cnt",  bus.other_cnt,  32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
